// File: rtl/pattern_scan_arbiter_if.sv
// Requester and result bundle for pattern_scan_arbiter.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; valid-side data is held until then.
interface pattern_scan_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORD_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [CNT_W-1:0]       res_count;
    logic                   res_ready;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_count
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_count
    );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// Round-robin scheduler sharing one serial non-overlapping pattern matcher among NREQ word sources.
// Words are scanned MSB-first; the per-word match count is returned tagged with the requester id.
module pattern_scan_arbiter #(
    parameter int               NREQ    = 4,
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_scan_arbiter_if.slave bus,
    output logic                 busy,
    output logic [1:0]           dbg_state
);
    localparam int ID_W = $clog2(NREQ);
    localparam int SC_W = $clog2(PAT_W + 1);
    localparam int BC_W = $clog2(WORD_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gid;
    logic [WORD_W-1:0] shreg;
    logic [PAT_W-1:0]  window;
    logic [SC_W-1:0]   since_cnt;
    logic [BC_W-1:0]   bitcnt;
    logic [CNT_W-1:0]  count;
    logic              res_valid_q;
    logic [ID_W-1:0]   res_id_q;
    logic [CNT_W-1:0]  res_count_q;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic [ID_W-1:0]   idx_c;
    int                idx;

    // Grant search starts at rr_ptr and wraps; ready is never raised while reset is asserted.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_c     = '0;
        if (state == S_IDLE && reset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                idx_c = ID_W'(idx);
                if (!grant_any && bus.req_valid[idx_c]) begin
                    grant_any = 1'b1;
                    grant_id  = idx_c;
                end
            end
            if (grant_any) grant[grant_id] = 1'b1;
        end
    end

    assign bus.req_ready = grant;

    logic              bit_in;
    logic [PAT_W-1:0]  win_nxt;
    logic [SC_W-1:0]   since_nxt;
    logic              hit;
    logic [CNT_W-1:0]  cnt_nxt;

    // since_cnt counts fresh bits since the last match, so a match needs PAT_W unused bits.
    always_comb begin
        bit_in    = shreg[WORD_W-1];
        win_nxt   = {window[PAT_W-2:0], bit_in};
        since_nxt = (since_cnt == SC_W'(PAT_W)) ? since_cnt : since_cnt + 1'b1;
        hit       = (win_nxt == PATTERN) && (since_nxt == SC_W'(PAT_W));
        cnt_nxt   = (hit && count != '1) ? count + 1'b1 : count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            gid         <= '0;
            shreg       <= '0;
            window      <= '0;
            since_cnt   <= '0;
            bitcnt      <= '0;
            count       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        shreg     <= bus.req_data[grant_id*WORD_W +: WORD_W];
                        gid       <= grant_id;
                        window    <= '0;
                        since_cnt <= '0;
                        count     <= '0;
                        bitcnt    <= '0;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    shreg     <= {shreg[WORD_W-2:0], 1'b0};
                    window    <= win_nxt;
                    count     <= cnt_nxt;
                    since_cnt <= hit ? '0 : since_nxt;
                    bitcnt    <= bitcnt + 1'b1;
                    if (bitcnt == BC_W'(WORD_W - 1)) begin
                        state       <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_id_q    <= gid;
                        res_count_q <= cnt_nxt;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        rr_ptr      <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_count = res_count_q;
    assign busy          = (state == S_SCAN) || (state == S_DONE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Randomized scoreboard bench for pattern_scan_arbiter with a greedy-scan reference model.
// Driver feeds per-requester word queues; a negedge monitor predicts grants and checks results.
module tb_pattern_scan_arbiter;
    localparam int NREQ   = 4;
    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 4;
    localparam int ID_W   = 2;
    localparam int EXP_W  = ID_W + CNT_W;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    pattern_scan_arbiter_if #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    pattern_scan_arbiter #(
        .NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: greedy leftmost scan, skipping the whole pattern after each hit.
    function automatic int ref_count(input logic [WORD_W-1:0] w);
        int n;
        int i;
        logic [PAT_W-1:0] seg;
        n = 0;
        i = 0;
        while (i + PAT_W <= WORD_W) begin
            seg = w[WORD_W-1-i -: PAT_W];
            if (seg == PATTERN) begin
                n++;
                i += PAT_W;
            end else begin
                i++;
            end
        end
        if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
        return n;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // driver state
    logic [WORD_W-1:0] pend_q[NREQ][$];
    logic [NREQ-1:0]   acc_vec = '0;
    int                rdy_mode = 0;
    bit                drop_en = 1'b0;

    function automatic int pending_total();
        int s;
        s = 0;
        for (int i = 0; i < NREQ; i++) s += pend_q[i].size();
        return s;
    endfunction

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_vec[i] && pend_q[i].size() > 0) void'(pend_q[i].pop_front());
            end
            acc_vec = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (pend_q[i].size() > 0) begin
                    bus.req_valid[i] = !(drop_en && $urandom_range(0, 3) == 0);
                    bus.req_data[i*WORD_W +: WORD_W] = pend_q[i][0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            case (rdy_mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = 1'($urandom_range(0, 1));
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    // scoreboard / monitor
    logic [EXP_W-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               acc_log_cyc[$];
    int               acc_log_id[$];
    int               hs_log_cyc[$];
    int               m_rr = 0;
    bit               m_idle = 1'b1;
    bit               seen = 1'b0;
    logic [EXP_W-1:0] held;

    initial begin
        int pred;
        logic [WORD_W-1:0] w;
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_rr   = 0;
                m_idle = 1'b1;
                seen   = 1'b0;
                exp_q.delete();
                exp_cyc_q.delete();
                acc_vec = '0;
            end else begin
                acc_vec = bus.req_valid & bus.req_ready;
                check("busy", int'(busy), int'(!m_idle));
                if (m_idle && |bus.req_valid) begin
                    pred = rr_pick(bus.req_valid, m_rr);
                    check("grant", int'(bus.req_ready), 1 << pred);
                    w = bus.req_data[pred*WORD_W +: WORD_W];
                    exp_q.push_back({ID_W'(pred), CNT_W'(ref_count(w))});
                    exp_cyc_q.push_back(cyc + 1);
                    acc_log_cyc.push_back(cyc + 1);
                    acc_log_id.push_back(pred);
                    m_idle = 1'b0;
                end else begin
                    check("ready_low", int'(bus.req_ready), 0);
                end
                if (bus.res_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_res_valid", 1, 0);
                    end else begin
                        e = exp_q[0];
                        if (!seen) begin
                            check("latency", cyc + 1 - exp_cyc_q[0], WORD_W + 1);
                            check("res_id", int'(bus.res_id), int'(e[EXP_W-1 -: ID_W]));
                            check("res_count", int'(bus.res_count), int'(e[CNT_W-1:0]));
                            seen = 1'b1;
                            held = {bus.res_id, bus.res_count};
                        end else begin
                            check("res_hold", int'({bus.res_id, bus.res_count}), int'(held));
                        end
                        if (bus.res_ready) begin
                            void'(exp_q.pop_front());
                            void'(exp_cyc_q.pop_front());
                            m_rr   = (int'(e[EXP_W-1 -: ID_W]) + 1) % NREQ;
                            m_idle = 1'b1;
                            seen   = 1'b0;
                            hs_log_cyc.push_back(cyc + 1);
                        end
                    end
                end
            end
        end
    end

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() > 0 || pending_total() > 0 || !m_idle) && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", int'(t >= budget), 0);
    endtask

    task automatic push_word(input int r, input logic [WORD_W-1:0] w);
        pend_q[r].push_back(w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        int base;
        int hs_base;
        int t;
        logic [WORD_W-1:0] table_w[6];
        table_w = '{8'hBB, 8'hB6, 8'h5A, 8'h00, 8'hFF, 8'h1B};

        // reset values, with a requester already asserting valid
        push_word(0, 8'hBB);
        repeat (3) @(posedge clk);
        #2;
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_id", int'(bus.res_id), 0);
        check("rst_res_count", int'(bus.res_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_state", int'(dbg_state), 0);
        reset = 1'b1;
        drain(200);

        // directed words
        push_word(1, 8'hB6); drain(200);
        push_word(2, 8'h5A); drain(200);
        push_word(3, 8'h00); drain(200);
        push_word(0, 8'hFF); drain(200);

        // round-robin from reset with all requesters waiting
        @(posedge clk); #2 reset = 1'b0;
        push_word(0, 8'h1B); push_word(1, 8'hB1);
        push_word(2, 8'hBB); push_word(3, 8'h6D);
        push_word(0, 8'hB0);
        repeat (2) @(posedge clk);
        base = acc_log_id.size();
        #2 reset = 1'b1;
        drain(400);
        if (acc_log_id.size() >= base + 5) begin
            check("rr_order0", acc_log_id[base], 0);
            check("rr_order1", acc_log_id[base+1], 1);
            check("rr_order2", acc_log_id[base+2], 2);
            check("rr_order3", acc_log_id[base+3], 3);
            check("rr_order4", acc_log_id[base+4], 0);
            for (int k = 1; k < 5; k++) check("rr_period", acc_log_cyc[base+k] - acc_log_cyc[base+k-1], WORD_W + 2);
        end else begin
            check("rr_grant_count", acc_log_id.size() - base, 5);
        end

        // backpressure
        @(posedge clk); #2 rdy_mode = 2;
        push_word(1, 8'hBB); push_word(2, 8'hB6);
        t = 0;
        while (!bus.res_valid && t < 50) begin @(negedge clk); t++; end
        check("bp_res_valid", int'(bus.res_valid), 1);
        repeat (20) @(posedge clk);
        #2;
        check("bp_valid_held", int'(bus.res_valid), 1);
        check("bp_busy", int'(busy), 1);
        base = acc_log_id.size();
        hs_base = hs_log_cyc.size();
        rdy_mode = 0;
        drain(200);
        if (acc_log_cyc.size() > base && hs_log_cyc.size() > hs_base)
            check("bp_regrant_gap", acc_log_cyc[base] - hs_log_cyc[hs_base], 1);
        else
            check("bp_regrant_seen", acc_log_cyc.size() - base, 1);

        // randomized traffic with valid drops and result backpressure
        drop_en = 1'b1;
        rdy_mode = 1;
        repeat (40) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 1) == 0) push_word($urandom_range(0, NREQ - 1), table_w[$urandom_range(0, 5)]);
            else push_word($urandom_range(0, NREQ - 1), WORD_W'($urandom));
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        drain(3000);
        drop_en = 1'b0;
        rdy_mode = 0;

        // reset in the middle of a scan
        @(posedge clk); #2;
        base = acc_log_id.size();
        push_word(2, 8'hBB);
        t = 0;
        while (acc_log_id.size() == base && t < 50) begin @(posedge clk); t++; end
        check("mid_accept_seen", acc_log_id.size() - base, 1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_res_valid", int'(bus.res_valid), 0);
        check("mid_rst_res_id", int'(bus.res_id), 0);
        check("mid_rst_res_count", int'(bus.res_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_req_ready", int'(bus.req_ready), 0);
        pend_q[2].delete();
        push_word(3, 8'hB6);
        push_word(0, 8'h5A);
        repeat (15) begin
            @(negedge clk);
            check("rst_no_result", int'(bus.res_valid), 0);
        end
        @(posedge clk);
        base = acc_log_id.size();
        #2 reset = 1'b1;
        drain(300);
        if (acc_log_id.size() > base) check("post_reset_first_grant", acc_log_id[base], 0);
        else check("post_reset_grant_seen", acc_log_id.size() - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
